// File: rtl/hps_sdram_port_arbiter.sv
// Round-robin arbiter that shares one HPS SDRAM Avalon-MM port between NUM_REQ
// fabric masters. Read return routing uses an in-order FIFO of requester IDs.
// MAX_PENDING must be a power of two and at least 2.
module hps_sdram_port_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 64,
    parameter  int MAX_PENDING = 8,
    localparam int BE_W        = DATA_W / 8,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    input  logic [NUM_REQ*BE_W-1:0]     req_byteenable,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [ADDR_W-1:0]           avm_address,
    output logic                        avm_read,
    output logic                        avm_write,
    output logic [DATA_W-1:0]           avm_writedata,
    output logic [BE_W-1:0]             avm_byteenable,
    input  logic                        avm_waitrequest,
    input  logic [DATA_W-1:0]           avm_readdata,
    input  logic                        avm_readdatavalid,
    output logic [CNT_W-1:0]            pending_count,
    output logic                        err_unexpected
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_PENDING);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     grant, grant_nxt, last_grant;
    logic [ID_W-1:0]     pick, cand;
    logic                found;
    logic [NUM_REQ-1:0]  eligible;

    logic [ID_W-1:0]     id_mem [MAX_PENDING];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                fifo_full, fifo_empty;
    logic                push, pop, rd_ok, accept;
    logic                sel_read, sel_write;

    assign fifo_full  = (pending_count == CNT_W'(MAX_PENDING));
    assign fifo_empty = (pending_count == '0);
    assign eligible   = req_write | (req_read & {NUM_REQ{~fifo_full}});

    assign sel_read   = req_read[grant];
    assign sel_write  = req_write[grant];

    assign avm_address    = req_address[grant*ADDR_W +: ADDR_W];
    assign avm_writedata  = req_writedata[grant*DATA_W +: DATA_W];
    assign avm_byteenable = req_byteenable[grant*BE_W +: BE_W];

    // A return frees a slot in the same cycle, so a read may be pushed into a full FIFO then.
    assign pop   = avm_readdatavalid & ~fifo_empty & ~reset_reset;
    assign rd_ok = ~fifo_full | pop;
    assign push  = accept & avm_read;

    assign req_readdata = avm_readdata;

    // Round-robin search for the first eligible requester after last_grant.
    always_comb begin
        pick  = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Next state, grant capture and command strobes; reset silences the port immediately.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (sel_write) begin
                    avm_write = 1'b1;
                end else if (sel_read && rd_ok) begin
                    avm_read = 1'b1;
                end
                if (!sel_write && !sel_read) begin
                    state_nxt = IDLE;
                end else if ((sel_write || (sel_read && rd_ok)) && !avm_waitrequest) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset_reset) begin
            avm_read  = 1'b0;
            avm_write = 1'b0;
            accept    = 1'b0;
        end
    end

    // Per-requester handshakes: stall everyone except the accepted grant; steer returns.
    always_comb begin
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        if (accept) begin
            req_waitrequest[grant] = 1'b0;
        end
        if (pop) begin
            req_readdatavalid[id_mem[rd_ptr]] = 1'b1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (accept) begin
                last_grant <= grant;
            end
        end
    end

    // Read-ID FIFO and outstanding count.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                pending_count <= pending_count + 1'b1;
            end else if (pop && !push) begin
                pending_count <= pending_count - 1'b1;
            end
        end
    end

    // Sticky flag for a read return with no outstanding read to route it to.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            err_unexpected <= 1'b0;
        end else if (avm_readdatavalid && fifo_empty) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hps_sdram_port_arbiter.sv
// Randomised bench for hps_sdram_port_arbiter against a transaction-level reference
// model (owner / round-robin pointer / queue of outstanding read IDs).
module tb_hps_sdram_port_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int MP      = 4;
    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_W   = $clog2(MP + 1);

    logic                       clk_clk = 1'b0;
    logic                       reset_reset;
    logic [NUM_REQ-1:0]         req_read, req_write;
    logic [NUM_REQ*ADDR_W-1:0]  req_address;
    logic [NUM_REQ*DATA_W-1:0]  req_writedata;
    logic [NUM_REQ*BE_W-1:0]    req_byteenable;
    logic [NUM_REQ-1:0]         req_waitrequest, req_readdatavalid;
    logic [DATA_W-1:0]          req_readdata;
    logic [ADDR_W-1:0]          avm_address;
    logic                       avm_read, avm_write;
    logic [DATA_W-1:0]          avm_writedata;
    logic [BE_W-1:0]            avm_byteenable;
    logic                       avm_waitrequest;
    logic [DATA_W-1:0]          avm_readdata;
    logic                       avm_readdatavalid;
    logic [CNT_W-1:0]           pending_count;
    logic                       err_unexpected;

    hps_sdram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MP)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .req_read(req_read), .req_write(req_write), .req_address(req_address),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .pending_count(pending_count), .err_unexpected(err_unexpected)
    );

    always #5 clk_clk = ~clk_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Requester stimulus state
    bit                 act_rd [NUM_REQ];
    bit                 act_wr [NUM_REQ];
    logic [ADDR_W-1:0]  s_addr [NUM_REQ];
    logic [DATA_W-1:0]  s_data [NUM_REQ];
    logic [BE_W-1:0]    s_be   [NUM_REQ];

    // Phase knobs (percent unless noted)
    int  p_start, rd_pct, p_wait, p_ret, p_stray, p_withdraw_pm, p_rst_pm;
    bit  force_rst, rst_when_busy;

    // Reference model
    int  owner   = -1;
    int  rr_last = NUM_REQ - 1;
    int  q[$];
    bit  m_err   = 1'b0;

    task automatic step();
        logic [NUM_REQ-1:0] exp_wait, exp_rdv;
        bit exp_rd, exp_wr, acc, popping, full, rst;
        int pick;
        @(negedge clk_clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!act_rd[i] && !act_wr[i]) begin
                if ($urandom_range(99) < p_start) begin
                    if ($urandom_range(99) < 5) begin
                        act_rd[i] = 1'b1; act_wr[i] = 1'b1;
                    end else if ($urandom_range(99) < rd_pct) begin
                        act_rd[i] = 1'b1;
                    end else begin
                        act_wr[i] = 1'b1;
                    end
                    s_addr[i] = $urandom;
                    s_data[i] = {$urandom, $urandom};
                    s_be[i]   = BE_W'($urandom);
                end
            end else if ($urandom_range(999) < p_withdraw_pm) begin
                act_rd[i] = 1'b0; act_wr[i] = 1'b0;
            end
            req_read[i]  = act_rd[i];
            req_write[i] = act_wr[i];
            req_address[i*ADDR_W +: ADDR_W]  = s_addr[i];
            req_writedata[i*DATA_W +: DATA_W] = s_data[i];
            req_byteenable[i*BE_W +: BE_W]    = s_be[i];
        end
        rst = force_rst || (rst_when_busy && owner >= 0) || ($urandom_range(999) < p_rst_pm);
        if (rst_when_busy && owner >= 0) rst_when_busy = 1'b0;
        reset_reset       = rst;
        avm_waitrequest   = ($urandom_range(99) < p_wait);
        avm_readdatavalid = (q.size() > 0) ? ($urandom_range(99) < p_ret)
                                           : ($urandom_range(99) < p_stray);
        avm_readdata      = {$urandom, $urandom};
        #1;

        full    = (q.size() >= MP);
        exp_rdv = '0;
        popping = 1'b0;
        if (!rst && avm_readdatavalid && q.size() > 0) begin
            exp_rdv[q[0]] = 1'b1;
            popping = 1'b1;
        end
        exp_wait = '1;
        exp_rd = 1'b0; exp_wr = 1'b0; acc = 1'b0;
        if (!rst && owner >= 0) begin
            if (act_wr[owner]) exp_wr = 1'b1;
            else if (act_rd[owner] && (!full || popping)) exp_rd = 1'b1;
            if ((exp_wr || exp_rd) && !avm_waitrequest) begin
                acc = 1'b1;
                exp_wait[owner] = 1'b0;
            end
        end

        check_val("waitrequest", 64'(req_waitrequest), 64'(exp_wait));
        check_val("readdatavalid", 64'(req_readdatavalid), 64'(exp_rdv));
        check_val("avm_read", 64'(avm_read), 64'(exp_rd));
        check_val("avm_write", 64'(avm_write), 64'(exp_wr));
        check_val("pending_count", 64'(pending_count), 64'(q.size()));
        check_val("err_unexpected", 64'(err_unexpected), 64'(m_err));
        if (exp_rd || exp_wr)
            check_val("avm_address", 64'(avm_address), 64'(s_addr[owner]));
        if (exp_wr) begin
            check_val("avm_writedata", avm_writedata, s_data[owner]);
            check_val("avm_byteenable", 64'(avm_byteenable), 64'(s_be[owner]));
        end
        if (popping)
            check_val("readdata", req_readdata, avm_readdata);

        if (rst) begin
            owner = -1; rr_last = NUM_REQ - 1; q.delete(); m_err = 1'b0;
        end else begin
            if (avm_readdatavalid && q.size() == 0) m_err = 1'b1;
            if (owner < 0) begin
                pick = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (rr_last + k) % NUM_REQ;
                    if (pick < 0 && (act_wr[c] || (act_rd[c] && !full))) pick = c;
                end
                if (popping) void'(q.pop_front());
                owner = pick;
            end else begin
                if (popping) void'(q.pop_front());
                if (acc) begin
                    if (exp_rd) q.push_back(owner);
                    act_rd[owner] = 1'b0; act_wr[owner] = 1'b0;
                    rr_last = owner;
                    owner = -1;
                end else if (!act_wr[owner] && !act_rd[owner]) begin
                    owner = -1;
                end
            end
        end
    endtask

    task automatic knobs(input int st, input int rp, input int wt, input int rt,
                         input int sy, input int wd, input int rs);
        p_start = st; rd_pct = rp; p_wait = wt; p_ret = rt;
        p_stray = sy; p_withdraw_pm = wd; p_rst_pm = rs;
    endtask

    initial begin
        reset_reset = 1'b1;
        req_read = '0; req_write = '0;
        req_address = '0; req_writedata = '0; req_byteenable = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            act_rd[i] = 1'b0; act_wr[i] = 1'b0;
            s_addr[i] = '0; s_data[i] = '0; s_be[i] = '0;
        end
        rst_when_busy = 1'b0;
        force_rst = 1'b1;
        knobs(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        force_rst = 1'b0;

        knobs(100, 0, 0, 0, 0, 0, 0);          // all masters writing, no stalls
        repeat (40) step();
        knobs(30, 100, 20, 40, 0, 0, 0);       // reads with in-order returns
        repeat (400) step();
        knobs(60, 70, 10, 5, 0, 0, 0);         // starve returns to fill the ID FIFO
        repeat (300) step();
        knobs(40, 50, 85, 30, 0, 0, 0);        // long port stalls
        repeat (300) step();
        knobs(0, 0, 0, 60, 0, 0, 0);           // drain, then stray returns
        repeat (60) step();
        knobs(0, 0, 0, 0, 15, 0, 0);
        repeat (60) step();
        for (int r = 0; r < 6; r++) begin      // reset landing while a grant is held
            knobs(50, 50, 60, 30, 5, 0, 0);
            rst_when_busy = 1'b1;
            repeat (60) step();
        end
        knobs(40, 50, 30, 25, 2, 10, 2);       // mixed traffic with withdrawals and resets
        repeat (2000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
